// File: rtl/fan_pkg.sv
// Shared constants and lane field helpers for the FAN adder result path.
// A lane is packed as {ctrl, row, data}, with data in the LSBs.
package fan_pkg;

    localparam int DW_DATA = 8;
    localparam int DW_ROW  = 4;
    localparam int DW_CTRL = 4;
    localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
    localparam int DW_ENT  = DW_ROW + DW_DATA;

    localparam int CTRL_VALID = 3;
    localparam int CTRL_DONE  = 2;

    typedef enum logic [1:0] {
        EDGE_NONE  = 2'b00,
        EDGE_LEFT  = 2'b01,
        EDGE_RIGHT = 2'b10,
        EDGE_BOTH  = 2'b11
    } edge_e;

    typedef logic [DW_LINE-1:0] lane_t;
    typedef logic [DW_ENT-1:0]  entry_t;

    function automatic logic [DW_CTRL-1:0] lane_ctrl(input lane_t l);
        return l[DW_LINE-1 -: DW_CTRL];
    endfunction

    function automatic logic [DW_ROW-1:0] lane_row(input lane_t l);
        return l[DW_DATA +: DW_ROW];
    endfunction

    function automatic logic [DW_DATA-1:0] lane_data(input lane_t l);
        return l[DW_DATA-1:0];
    endfunction

    function automatic logic lane_done(input lane_t l);
        return l[DW_ENT + CTRL_DONE];
    endfunction

    function automatic edge_e lane_edge(input lane_t l);
        return edge_e'(l[DW_ENT +: 2]);
    endfunction

    // {row, data} already sits in the low bits of a lane
    function automatic entry_t lane_entry(input lane_t l);
        return l[DW_ENT-1:0];
    endfunction

endpackage

// File: rtl/fan_lane_compact.sv
// Combinational compaction of done lanes into consecutive {row, data} slots,
// preserving ascending lane order; o_k is the number of done lanes.
module fan_lane_compact #(
    parameter int NUM_IN  = 6,
    parameter int DW_DATA = fan_pkg::DW_DATA,
    parameter int DW_ROW  = fan_pkg::DW_ROW,
    parameter int DW_CTRL = fan_pkg::DW_CTRL,
    localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
    localparam int DW_ENT  = DW_ROW + DW_DATA,
    localparam int KW      = $clog2(NUM_IN + 1)
) (
    input  logic [NUM_IN*DW_LINE-1:0] i_lanes,
    input  logic [NUM_IN-1:0]         i_done,
    output logic [NUM_IN*DW_ENT-1:0]  o_packed,
    output logic [KW-1:0]             o_k
);

    logic [KW-1:0] w_slot;
    logic          w_unused_ctrl;

    // w_slot holds the exclusive prefix popcount: the slot for lane i
    // is the number of done lanes strictly below it.
    always_comb begin
        o_packed      = '0;
        w_slot        = '0;
        w_unused_ctrl = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            w_unused_ctrl = w_unused_ctrl ^ (^i_lanes[i*DW_LINE + DW_ENT +: DW_CTRL]);
            if (i_done[i]) begin
                o_packed[int'(w_slot)*DW_ENT +: DW_ENT] = i_lanes[i*DW_LINE +: DW_ENT];
                w_slot = w_slot + KW'(1);
            end
        end
        o_k = w_slot;
    end

endmodule

// File: rtl/fan_result_collector.sv
// Collects done lanes from the last FAN adder level into a circular FIFO
// and drains one {row, data} result per cycle (first-word-fall-through).
module fan_result_collector
    import fan_pkg::*;
#(
    parameter int DW_DATA = fan_pkg::DW_DATA,
    parameter int DW_ROW  = fan_pkg::DW_ROW,
    parameter int DW_CTRL = fan_pkg::DW_CTRL,
    parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
    parameter int NUM_IN  = 6,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*DW_LINE-1:0] in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW_ROW-1:0]         out_row,
    output logic [DW_DATA-1:0]        out_data,
    output logic [AW:0]               count,
    output logic                      overflow
);

    localparam int DW_ENT = DW_ROW + DW_DATA;
    localparam int KW     = $clog2(NUM_IN + 1);

    logic [DW_ENT-1:0]        r_mem [DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [AW:0]              r_count;
    logic                     r_overflow;

    logic [NUM_IN-1:0]        w_done;
    logic [NUM_IN*DW_ENT-1:0] w_packed;
    logic [KW-1:0]            w_k;
    logic                     w_in_ready;
    logic                     w_out_valid;
    logic                     w_push;
    logic                     w_pop;

    always_comb begin
        w_done = '0;
        for (int unsigned i = 0; i < NUM_IN; i++)
            w_done[i] = in[i*DW_LINE + DW_ENT + CTRL_DONE];
    end

    fan_lane_compact #(
        .NUM_IN  (NUM_IN),
        .DW_DATA (DW_DATA),
        .DW_ROW  (DW_ROW),
        .DW_CTRL (DW_CTRL)
    ) u_compact (
        .i_lanes  (in),
        .i_done   (w_done),
        .o_packed (w_packed),
        .o_k      (w_k)
    );

    // Room for a worst-case beat is judged from registered count only
    assign w_in_ready  = (r_count <= (AW+1)'(DEPTH - NUM_IN));
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(w_k);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (w_push ? (AW+1)'(w_k) : '0) - (AW+1)'(w_pop);
            if (in_valid && !w_in_ready)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            for (int unsigned j = 0; j < NUM_IN; j++) begin
                if (KW'(j) < w_k)
                    r_mem[r_wr_ptr + AW'(j)] <= w_packed[j*DW_ENT +: DW_ENT];
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_row   = w_out_valid ? r_mem[r_rd_ptr][DW_ENT-1 -: DW_ROW] : '0;
    assign out_data  = w_out_valid ? r_mem[r_rd_ptr][DW_DATA-1:0] : '0;
    assign count     = r_count;
    assign overflow  = r_overflow;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        r_count <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_fan_result_collector.sv
// Scoreboard bench for fan_result_collector: a queue model of the FIFO
// contents is compared against the DUT on every falling edge.
module tb_fan_result_collector;

    localparam int NUM_IN = 6;
    localparam int DEPTH  = 16;
    localparam int LW     = 16;
    localparam int BW     = NUM_IN * LW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [BW-1:0] in_bus = '0;
    logic          in_ready;
    logic          out_valid;
    logic [3:0]    out_row;
    logic [7:0]    out_data;
    logic [4:0]    count;
    logic          overflow;

    fan_result_collector #(
        .NUM_IN (NUM_IN),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] q[$];
    logic        exp_ovf = 1'b0;
    logic        chk_en = 1'b0;
    int          m_sz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: FIFO contents as a queue; beats accepted only if at least NUM_IN slots free
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_ovf <= 1'b0;
            chk_en  <= 1'b1;
        end else begin
            m_sz = q.size();
            if (out_ready && m_sz != 0)
                void'(q.pop_front());
            if (in_valid) begin
                if (m_sz <= DEPTH - NUM_IN) begin
                    for (int i = 0; i < NUM_IN; i++)
                        if (in_bus[i*LW + 14])
                            q.push_back(in_bus[i*LW +: 12]);
                end else begin
                    exp_ovf <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() <= DEPTH - NUM_IN));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            if (q.size() != 0) begin
                chk("out_row", 32'(out_row), 32'(q[0][11:8]));
                chk("out_data", 32'(out_data), 32'(q[0][7:0]));
            end else begin
                chk("out_row_idle", 32'(out_row), 32'd0);
                chk("out_data_idle", 32'(out_data), 32'd0);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [BW-1:0] bus, input logic ordy);
        @(negedge clk);
        #1;
        rst       = r;
        in_valid  = v;
        in_bus    = bus;
        out_ready = ordy;
    endtask

    function automatic logic [15:0] lane(input logic [3:0] c, input logic [3:0] r, input logic [7:0] d);
        return {c, r, d};
    endfunction

    // Lanes 0..n-1 done (ctrl 0111, row=i, data=base+i); the rest carry ctrl 1000
    function automatic logic [BW-1:0] beat_n(input int n, input int base);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_IN; i++)
            b[i*LW +: LW] = (i < n) ? lane(4'b0111, 4'(i), 8'(base + i))
                                    : lane(4'b1000, 4'(i), 8'(base + i));
        return b;
    endfunction

    initial begin
        logic [BW-1:0] b;

        drive(1, 0, '0, 0);
        drive(1, 0, '0, 0);

        b = '0;
        b[2*LW +: LW] = lane(4'b0111, 4'd3, 8'h25);
        drive(0, 1, b, 1);
        repeat (3) drive(0, 0, '0, 1);

        drive(0, 1, beat_n(6, 1), 1);
        repeat (8) drive(0, 0, '0, 1);

        b = '0;
        b[0*LW +: LW] = lane(4'b1000, 4'd1, 8'h11);
        b[1*LW +: LW] = lane(4'b1001, 4'd2, 8'h12);
        b[2*LW +: LW] = lane(4'b1010, 4'd3, 8'h13);
        b[3*LW +: LW] = lane(4'b0000, 4'd4, 8'h14);
        b[4*LW +: LW] = lane(4'b1000, 4'd5, 8'h15);
        b[5*LW +: LW] = lane(4'b1001, 4'd6, 8'h16);
        drive(0, 1, b, 1);
        repeat (3) drive(0, 0, '0, 1);

        drive(0, 1, beat_n(6, 8'h10), 0);
        drive(0, 1, beat_n(6, 8'h20), 0);
        drive(0, 1, beat_n(6, 8'h30), 0);
        repeat (2) drive(0, 0, '0, 0);
        repeat (14) drive(0, 0, '0, 1);

        drive(1, 0, '0, 0);
        drive(0, 1, beat_n(6, 8'h40), 0);
        drive(0, 1, beat_n(6, 8'h50), 0);
        repeat (2) drive(0, 0, '0, 1);
        drive(0, 1, beat_n(4, 8'h60), 0);
        repeat (12) drive(0, 0, '0, 1);
        drive(0, 1, beat_n(4, 8'h70), 1);
        drive(0, 0, '0, 0);

        drive(1, 1, beat_n(6, 8'h80), 1);
        repeat (2) drive(0, 0, '0, 0);

        repeat (500) begin
            b = '0;
            for (int i = 0; i < NUM_IN; i++)
                b[i*LW +: LW] = 16'($urandom);
            drive(0, ($urandom_range(0, 9) < 7), b, ($urandom_range(0, 9) < 6));
        end

        for (int n = 0; n < 64 && q.size() != 0; n++)
            drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);
        chk("drain_empty", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
